// File: rtl/io_uart_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | io_uart_port: CPU I/O responder with TX FIFO + 8N1 transmitter and a     |
// | single-byte 8N1 receiver. Optional IRQ logic under `IO_UART_IRQ_EN`.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module io_uart_port #(
  parameter int CLKS_PER_BIT    = 16,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ior,
  input  logic       iow,
  input  logic [3:0] port,
  input  logic [7:0] ioout,
  output logic [7:0] iodata,
  output logic       txd,
  input  logic       rxd,
  output logic       irq
);

  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  logic rd_data, rd_stat, wr_data, wr_ctrl;
  assign rd_data = ior && (port == 4'd0);
  assign rd_stat = ior && (port == 4'd1);
  assign wr_data = iow && (port == 4'd0);
  assign wr_ctrl = iow && (port == 4'd2);

  // TX FIFO: extra pointer bit separates full from empty
  logic [7:0]  fifo_mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        fifo_empty, fifo_full, push, pop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  uart_state_e      tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             txd_q, txd_d;

  assign push     = wr_data && !fifo_full;
  assign pop      = (tx_state_q == ST_IDLE) && !fifo_empty;
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  assign txd      = txd_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    unique case (tx_state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          tx_state_d = ST_START;
          tx_shift_d = fifo_mem_q[rd_ptr_q[AW-1:0]];
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = '0;
          tx_idx_d   = 3'd0;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = ST_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_idx_d   = tx_idx_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = ST_IDLE;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // Receiver; third sync stage only serves falling-edge detection
  logic             rx_s1_q, rx_s2_q, rx_s3_q;
  uart_state_e      rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d, rx_commit;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_commit  = 1'b0;
    unique case (rx_state_q)
      ST_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_state_d = ST_START;
          rx_cnt_d   = '0;
        end
      end
      ST_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = 3'd0;
          rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) rx_state_d = ST_STOP;
          else                  rx_idx_d   = rx_idx_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_state_d = ST_IDLE;
          rx_cnt_d   = '0;
          rx_commit  = rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // A commit racing a data read leaves the new byte valid without overrun
  always_comb begin
    rx_data_d    = rx_commit ? rx_shift_q : rx_data_q;
    rx_valid_d   = rx_commit ? 1'b1 : (rd_data ? 1'b0 : rx_valid_q);
    rx_overrun_d = rx_overrun_q;
    if (rx_commit && rx_valid_q && !rd_data) rx_overrun_d = 1'b0 | 1'b1;
    else if (wr_ctrl && ioout[1])            rx_overrun_d = 1'b0;
  end

  logic irq_en;

`ifdef IO_UART_IRQ_EN
  logic irq_en_q, irq_en_d, tx_empty_edge_q, tx_empty_edge_d, irq_q, irq_d;

  always_comb begin
    irq_en_d        = wr_ctrl ? ioout[0] : irq_en_q;
    tx_empty_edge_d = tx_empty_edge_q;
    if (!fifo_empty && (wr_ptr_d == rd_ptr_d)) tx_empty_edge_d = 1'b1;
    else if (rd_stat)                          tx_empty_edge_d = 1'b0;
    irq_d = irq_en_q & (rx_valid_q | tx_empty_edge_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q        <= 1'b0;
      tx_empty_edge_q <= 1'b0;
      irq_q           <= 1'b0;
    end else begin
      irq_en_q        <= irq_en_d;
      tx_empty_edge_q <= tx_empty_edge_d;
      irq_q           <= irq_d;
    end
  end

  assign irq    = irq_q;
  assign irq_en = irq_en_q;
`else
  assign irq    = 1'b0;
  assign irq_en = 1'b0;
`endif

  always_comb begin
    iodata = 8'h00;
    unique case (port)
      4'd0:    iodata = rx_data_q;
      4'd1:    iodata = {4'b0, rx_overrun_q, rx_valid_q, fifo_full, fifo_empty};
      4'd2:    iodata = {7'b0, irq_en};
      default: iodata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= ioout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tx_state_q   <= ST_IDLE;
      tx_cnt_q     <= '0;
      tx_idx_q     <= 3'd0;
      tx_shift_q   <= 8'h00;
      txd_q        <= 1'b1;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_s3_q      <= 1'b1;
      rx_state_q   <= ST_IDLE;
      rx_cnt_q     <= '0;
      rx_idx_q     <= 3'd0;
      rx_shift_q   <= 8'h00;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_idx_q     <= tx_idx_d;
      tx_shift_q   <= tx_shift_d;
      txd_q        <= txd_d;
      rx_s1_q      <= rxd;
      rx_s2_q      <= rx_s1_q;
      rx_s3_q      <= rx_s2_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_idx_q     <= rx_idx_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

endmodule
`default_nettype wire
